// File: rtl/rmach_pkg.sv
// Shared definitions for the register-machine execute stage.
// Holds the sequencer state encoding, opcode / ALU / shift constants and
// the instruction field extractors used by the sequencer and its ALU.
package rmach_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RN_W_DEF   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RA,
    S_RB,
    S_EX,
    S_WB,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // ALU sub-op field under OP_ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // ALU-field values that select the two MOV forms under OP_MOV
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  function automatic logic [2:0] f_op(input logic [15:0] ins);
    return ins[15:13];
  endfunction

  function automatic logic [1:0] f_alu(input logic [15:0] ins);
    return ins[12:11];
  endfunction

  function automatic logic [2:0] f_rn(input logic [15:0] ins);
    return ins[10:8];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] ins);
    return ins[7:5];
  endfunction

  function automatic logic [1:0] f_sh(input logic [15:0] ins);
    return ins[4:3];
  endfunction

  function automatic logic [2:0] f_rm(input logic [15:0] ins);
    return ins[2:0];
  endfunction

  function automatic logic [7:0] f_imm8(input logic [15:0] ins);
    return ins[7:0];
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational shifter + ALU for the execute stage.
// Ports:
//   a_i, b_i  operands (b_i is shifted before use)
//   sh_i      shift select (pass / LSL1 / LSR1 / ASR1)
//   alu_i     ALU op (ADD / CMP / AND / MVN)
//   result_o  ALU result (CMP produces a - shift(b))
//   n_o, v_o, z_o  negative, signed-overflow, zero flags for result_o
module alu_shift_unit
  import rmach_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        sh_i,
  input  logic [1:0]        alu_i,
  output logic [DATA_W-1:0] result_o,
  output logic              n_o,
  output logic              v_o,
  output logic              z_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] b_sh;

  // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    b_sh = b_i;
    unique case (sh_i)
      SH_LSL1: b_sh = {b_i[MSB-1:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b_i[MSB:1]};
      SH_ASR1: b_sh = {b_i[MSB], b_i[MSB:1]};
      default: b_sh = b_i;
    endcase
  end

  always_comb begin
    result_o = '0;
    v_o      = 1'b0;
    unique case (alu_i)
      ALU_ADD: begin
        result_o = a_i + b_sh;
        // overflow: like-signed operands produce an opposite-signed sum
        v_o = (a_i[MSB] == b_sh[MSB]) && (result_o[MSB] != a_i[MSB]);
      end
      ALU_CMP: begin
        result_o = a_i - b_sh;
        // overflow: unlike-signed operands and the sign of a is lost
        v_o = (a_i[MSB] != b_sh[MSB]) && (result_o[MSB] != a_i[MSB]);
      end
      ALU_AND: result_o = a_i & b_sh;
      ALU_MVN: result_o = ~b_sh;
      default: result_o = '0;
    endcase
    n_o = result_o[MSB];
    z_o = (result_o == '0);
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle controller and execute stage in front of an 8x16 register
// file with one combinational read port and one clocked write port.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start, instr     instruction handshake (sampled only in IDLE)
//   rf_data_out      regfile read data for readnum
//   readnum          regfile read select (Rn in RA, Rm in RB, else 0)
//   writenum, write, rf_data_in   regfile write port (active only in WB)
//   busy             high from the cycle after acceptance through DONE
//   done, illegal    retire pulse, with illegal for unsupported opcodes
//   status           {N,V,Z}, updated by ADD/CMP/AND/MVN in EX
module alu_instr_sequencer
  import rmach_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RN_W   = RN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [RN_W-1:0]   readnum,
  output logic [RN_W-1:0]   writenum,
  output logic              write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [2:0]        status
);

  state_e            state_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [RN_W-1:0]   readnum_q, writenum_q;
  logic              write_q, busy_q, done_q, illegal_q;
  logic [DATA_W-1:0] rf_data_in_q;
  logic [2:0]        status_q;

  // MOV reg reuses the adder with A forced to zero, so A need not be read.
  logic              ir_is_mov;
  logic [DATA_W-1:0] alu_a;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_n, alu_v, alu_z;

  assign ir_is_mov = (f_op(ir_q) == OP_MOV);
  assign alu_a     = ir_is_mov ? '0 : a_q;
  assign alu_op    = ir_is_mov ? ALU_ADD : f_alu(ir_q);

  alu_shift_unit #(.DATA_W(DATA_W)) u_alu (
    .a_i      (alu_a),
    .b_i      (b_q),
    .sh_i     (f_sh(ir_q)),
    .alu_i    (alu_op),
    .result_o (alu_res),
    .n_o      (alu_n),
    .v_o      (alu_v),
    .z_o      (alu_z)
  );

  // Outputs are registered: each transition loads the values the next
  // state presents, so the port pins never decode state combinationally.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      readnum_q    <= '0;
      writenum_q   <= '0;
      write_q      <= 1'b0;
      rf_data_in_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      status_q     <= '0;
    end else begin
      readnum_q    <= '0;
      writenum_q   <= '0;
      write_q      <= 1'b0;
      rf_data_in_q <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ir_q   <= instr;
            busy_q <= 1'b1;
            if (f_op(instr) == OP_MOV && f_alu(instr) == MOV_IMM) begin
              state_q      <= S_WB;
              write_q      <= 1'b1;
              writenum_q   <= RN_W'(f_rn(instr));
              rf_data_in_q <= {{(DATA_W-8){instr[7]}}, f_imm8(instr)};
            end else if (f_op(instr) == OP_MOV && f_alu(instr) == MOV_REG) begin
              state_q   <= S_RB;
              readnum_q <= RN_W'(f_rm(instr));
            end else if (f_op(instr) == OP_ALU) begin
              state_q   <= S_RA;
              readnum_q <= RN_W'(f_rn(instr));
            end else begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end
        end
        S_RA: begin
          a_q       <= rf_data_out;
          state_q   <= S_RB;
          readnum_q <= RN_W'(f_rm(ir_q));
        end
        S_RB: begin
          b_q     <= rf_data_out;
          state_q <= S_EX;
        end
        S_EX: begin
          c_q <= alu_res;
          if (!ir_is_mov) status_q <= {alu_n, alu_v, alu_z};
          if (!ir_is_mov && f_alu(ir_q) == ALU_CMP) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q      <= S_WB;
            write_q      <= 1'b1;
            writenum_q   <= RN_W'(f_rd(ir_q));
            rf_data_in_q <= alu_res;
          end
        end
        S_WB: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign readnum    = readnum_q;
  assign writenum   = writenum_q;
  assign write      = write_q;
  assign rf_data_in = rf_data_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign status     = status_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench: an 8x16 regfile environment around the sequencer,
// and a reference model that computes each instruction's architectural
// effect (write, flags, latency) straight from the field definitions.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic [15:0] rf_data_out;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [15:0] rf_data_in;
  logic        busy, done, illegal;
  logic [2:0]  status;

  int checks   = 0;
  int failures = 0;

  // Regfile environment: combinational read, write on rising clk.
  logic [15:0] regs [8];
  assign rf_data_out = regs[readnum];
  always @(posedge clk) if (write) regs[writenum] <= rf_data_in;

  // Reference architectural state.
  logic [15:0] ref_regs [8];
  logic [2:0]  ref_status;

  always #5 clk = ~clk;

  alu_instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .rf_data_out (rf_data_out),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .rf_data_in  (rf_data_in),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .status      (status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] shifted(input logic [15:0] b, input logic [1:0] sh);
    case (sh)
      2'd0: return b;
      2'd1: return b << 1;
      2'd2: return b >> 1;
      default: return (b >> 1) | (b & 16'h8000);
    endcase
  endfunction

  function automatic int as_signed(input logic [15:0] x);
    return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
  endfunction

  // Architectural model: expected latency, illegal flag, writeback; updates
  // ref_regs/ref_status to the post-instruction state.
  task automatic model(input logic [15:0] ins, output int lat, output bit ill,
                       output bit wr, output logic [2:0] wn, output logic [15:0] wd);
    int op, alu, rn, rd, sh, rm, imm, r;
    logic [15:0] a, b, res;
    bit v;
    op  = int'(ins[15:13]); alu = int'(ins[12:11]);
    rn  = int'(ins[10:8]);  rd  = int'(ins[7:5]);
    sh  = int'(ins[4:3]);   rm  = int'(ins[2:0]);
    imm = int'(ins[7:0]);
    lat = 1; ill = 1'b0; wr = 1'b0; wn = 3'd0; wd = 16'd0;
    if (op == 6 && alu == 2) begin
      if (imm > 127) imm -= 256;
      r = imm;
      lat = 2; wr = 1'b1; wn = 3'(rn); wd = r[15:0];
    end else if (op == 6 && alu == 0) begin
      lat = 4; wr = 1'b1; wn = 3'(rd); wd = shifted(ref_regs[rm], 2'(sh));
    end else if (op == 5) begin
      a = ref_regs[rn];
      b = shifted(ref_regs[rm], 2'(sh));
      v = 1'b0;
      case (alu)
        0: begin r = as_signed(a) + as_signed(b); res = r[15:0]; v = (r > 32767) || (r < -32768); end
        1: begin r = as_signed(a) - as_signed(b); res = r[15:0]; v = (r > 32767) || (r < -32768); end
        2: res = a & b;
        default: res = ~b;
      endcase
      ref_status = {res[15], v, res == 16'd0};
      if (alu == 1) lat = 4;
      else begin lat = 5; wr = 1'b1; wn = 3'(rd); wd = res; end
    end else begin
      ill = 1'b1;
    end
    if (wr) ref_regs[wn] = wd;
  endtask

  // Issue one instruction and watch 8 cycles. With noisy set, start stays
  // high with random instr bits until done, which must be ignored.
  task automatic run_instr(input logic [15:0] ins, input bit noisy);
    int lat, done_cyc, ndone, nw;
    bit ill, wr, ill_seen, busy_err;
    logic [2:0] wn, seen_wn;
    logic [15:0] wd, seen_wd;
    model(ins, lat, ill, wr, wn, wd);
    done_cyc = 0; ndone = 0; nw = 0; ill_seen = 1'b0; busy_err = 1'b0;
    seen_wn = 3'd0; seen_wd = 16'd0;
    @(negedge clk);
    start = 1'b1; instr = ins;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (write) begin nw++; seen_wn = writenum; seen_wd = rf_data_in; end
      if (done) begin
        ndone++;
        if (done_cyc == 0) begin done_cyc = n; ill_seen = illegal; end
      end
      if ((done_cyc == 0 || done_cyc == n) && !busy) busy_err = 1'b1;
      if (done_cyc != 0 && done_cyc < n && busy) busy_err = 1'b1;
      start = noisy && (done_cyc == 0);
      instr = 16'($urandom);
    end
    start = 1'b0;
    check("done_latency", done_cyc, lat);
    check("done_count", ndone, 1);
    check("illegal", ill_seen, ill);
    check("write_count", nw, wr ? 1 : 0);
    if (wr) begin
      check("writenum", seen_wn, wn);
      check("wdata", seen_wd, wd);
    end
    check("status", status, ref_status);
    check("busy_window", busy_err, 1'b0);
  endtask

  // Start an ADD/AND/MVN, assert reset during EX and confirm the write is lost.
  task automatic reset_in_ex(input logic [15:0] ins);
    bit wr_seen;
    wr_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; instr = ins;
    @(negedge clk); start = 1'b0; wr_seen |= write;   // RA
    @(negedge clk); wr_seen |= write;                  // RB
    @(negedge clk); wr_seen |= write;                  // EX
    check("busy_in_ex", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    wr_seen |= write;
    check("rst_ex_write", wr_seen, 1'b0);
    check("rst_ex_busy", busy, 1'b0);
    check("rst_ex_done", done, 1'b0);
    check("rst_ex_status", status, 3'b000);
    reset = 1'b0;
    ref_status = 3'b000;
    @(negedge clk);
    check("rst_ex_dest", regs[ins[7:5]], ref_regs[ins[7:5]]);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] ins;
    int kind;
    ins  = 16'($urandom);
    kind = $urandom_range(0, 9);
    if (kind <= 2)      ins[15:11] = 5'b11010;
    else if (kind == 3) ins[15:11] = 5'b11000;
    else if (kind <= 7) ins[15:13] = 3'b101;
    else if (kind == 8) ins[12:11] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
    else begin
      ins[15:13] = 3'($urandom_range(0, 4));
      if (ins[15:13] == 3'b101) ins[15:13] = 3'b111;
    end
    if (kind == 8) ins[15:13] = 3'b110;
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin regs[i] = 16'd0; ref_regs[i] = 16'd0; end
    ref_status = 3'b000;
    reset = 1'b1; start = 1'b0; instr = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_readnum", readnum, 3'd0);
    check("rst_writenum", writenum, 3'd0);
    check("rst_write", write, 1'b0);
    check("rst_wdata", rf_data_in, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_status", status, 3'b000);

    // reset wins over a simultaneous start
    start = 1'b1; instr = 16'hD007;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy, 1'b0);

    // Directed corner sequence
    run_instr(16'hD007, 1'b0);   // MOV R0,#7
    run_instr(16'hD1FE, 1'b0);   // MOV R1,#0xFE -> 0xFFFE
    run_instr(16'hD102, 1'b0);   // MOV R1,#2
    run_instr(16'hA148, 1'b0);   // ADD R2,R1,R0,LSL#1 -> 0x0010
    run_instr(16'hA248, 1'b0);   // ADD R2,R2,R0,LSL#1
    run_instr(16'hA800, 1'b0);   // CMP R0,R0 -> Z
    run_instr(16'hD3FF, 1'b0);   // MOV R3,#-1
    run_instr(16'hC073, 1'b0);   // MOV R3,R3,LSR#1 -> 0x7FFF
    run_instr(16'hD4FF, 1'b0);   // MOV R4,#-1
    run_instr(16'hAB04, 1'b0);   // CMP R3,R4 -> N,V
    run_instr(16'hB8A0, 1'b1);   // MVN R5,R0 with start held busy
    run_instr(16'hC0DD, 1'b0);   // MOV R6,R5,ASR#1 -> 0xFFFC
    run_instr(16'h0000, 1'b0);   // illegal
    run_instr(16'hC800, 1'b0);   // 110/01: illegal MOV form
    reset_in_ex(16'hA0E8);       // ADD R7,R0,R0,LSL#1 lost to reset

    for (int i = 0; i < 250; i++)
      run_instr(rand_instr(), ($urandom_range(0, 3) == 0));

    reset_in_ex(16'hB0E1);       // AND R7,R0,R1 lost to reset
    for (int i = 0; i < 8; i++) check("final_reg", regs[i], ref_regs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
